iter_alu_exec: RTL

- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller and computes the result over a valid/ready handshake.
- Logic, arithmetic and compare operations complete in one cycle.
- Shifts are iterative: one bit position per cycle. This removes the barrel shifter from the EX critical path.
- `in_ready` low is the pipeline stall request to the hazard unit.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/iter_shifter.sv | 54 +++++
 rtl/iter_alu_exec.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states
// and a helper used by the datapath to route shift operations.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_EQ   = 4'b1000,
    OP_NE   = 4'b1001,
    OP_LT   = 4'b1010,
    OP_GE   = 4'b1011,
    OP_XOR  = 4'b1100,
    OP_PASS = 4'b1111
  } alu_op_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/iter_shifter.sv
// Bit-serial shifter: moves the accumulator one position per step and
// flags the step that completes the requested shift amount.
module iter_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  alu_op_t            op,
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  acc_nxt,
  output logic               done
);

  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  alu_op_t            op_q;

  // Single-position shift of the accumulator for the latched direction
  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_SLL:  acc_nxt = {acc[DATA_W-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[DATA_W-1:1]};
      OP_SRA:  acc_nxt = {acc[DATA_W-1], acc[DATA_W-1:1]};
      default: acc_nxt = acc;
    endcase
  end

  // Last step: the value in acc_nxt is the final shifted result
  assign done = step && (cnt == SHAMT_W'(1));

  // Accumulator and remaining-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_SLL;
    end else if (load) begin
      acc  <= din;
      cnt  <= shamt;
      op_q <= op;
    end else if (step) begin
      acc  <= acc_nxt;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/iter_alu_exec.sv
// Execute-stage ALU with valid/ready handshake. Single-cycle ops are a
// combinational case; shifts are delegated to the bit-serial shifter.
module iter_alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              BrTaken,
  output logic              IllegalOp
);

  state_t             state;
  alu_op_t            op_in;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               start_shift;
  logic [DATA_W-1:0]  res_c;
  logic               br_c;
  logic               ill_c;
  logic               lt_s;
  logic [DATA_W-1:0]  sh_nxt;
  logic               sh_done;

  assign op_in       = alu_op_t'(Operation);
  assign shamt       = SrcB[SHAMT_W-1:0];
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift(op_in) && (shamt != '0);
  assign lt_s        = $signed(SrcA) < $signed(SrcB);

  iter_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (start_shift),
    .step    (state == SHIFT),
    .op      (op_in),
    .din     (SrcA),
    .shamt   (shamt),
    .acc_nxt (sh_nxt),
    .done    (sh_done)
  );

  // Single-cycle result; shift codes only land here with a zero amount
  always_comb begin
    res_c = '0;
    br_c  = 1'b0;
    ill_c = 1'b0;
    case (Operation)
      OP_AND:  res_c = SrcA & SrcB;
      OP_OR:   res_c = SrcA | SrcB;
      OP_XOR:  res_c = SrcA ^ SrcB;
      OP_ADD:  res_c = SrcA + SrcB;
      OP_SUB:  res_c = SrcA - SrcB;
      OP_SLL, OP_SRL, OP_SRA: res_c = SrcA;
      OP_SLT:  res_c = DATA_W'(lt_s);
      OP_EQ: begin
        br_c  = (SrcA == SrcB);
        res_c = DATA_W'(br_c);
      end
      OP_NE: begin
        br_c  = (SrcA != SrcB);
        res_c = DATA_W'(br_c);
      end
      OP_LT: begin
        br_c  = lt_s;
        res_c = DATA_W'(br_c);
      end
      OP_GE: begin
        br_c  = !lt_s;
        res_c = DATA_W'(br_c);
      end
      OP_PASS: res_c = SrcB;
      default: ill_c = 1'b1;
    endcase
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ALUResult <= '0;
      BrTaken   <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_shift) begin
            state <= SHIFT;
          end else if (accept) begin
            ALUResult <= res_c;
            BrTaken   <= br_c;
            IllegalOp <= ill_c;
            state     <= DONE;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            ALUResult <= sh_nxt;
            BrTaken   <= 1'b0;
            IllegalOp <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
